// File: rtl/apex_sdo_rx_if.sv
// apex_sdo_rx_if: received-word output stream of the APEX7 psdo receiver.
// The receiver drives the word and its tags (master); the consumer returns
// prready (slave). WORD_W must match the receiver instance.
interface apex_sdo_rx_if #(
    parameter int WORD_W = 8
);
    logic              prvalid;
    logic              prready;
    logic [WORD_W-1:0] prdata;
    logic [2:0]        prch;
    logic              pcomperr;

    modport master (
        output prvalid,
        output prdata,
        output prch,
        output pcomperr,
        input  prready
    );

    modport slave (
        input  prvalid,
        input  prdata,
        input  prch,
        input  pcomperr,
        output prready
    );
endinterface

// File: rtl/apex_sdo_rx.sv
// apex_sdo_rx: serial-data receiver for the APEX7 psdo stream.
// Frames are WORD_W data bits (LSB first) plus one even-parity bit, closed
// by pend. Completed words go to a valid/ready output register tagged with
// the channel id latched at the first data bit; pcat holds one credit bit
// per channel, cleared while that channel's word is undelivered.
// Optional build macro APEX_SDO_RX_TIMEOUT_EN: aborts a frame after 16
// consecutive strobe-free cycles in SHIFT, PAR or END, pulsing pfrmerr.
module apex_sdo_rx #(
    parameter int WORD_W = 8
) (
    input  logic       pclk,
    input  logic       prst,
    input  logic       psdo,
    input  logic       pfbi,
    input  logic       pend,
    input  logic [2:0] pibt,
    input  logic       piclr,
    apex_sdo_rx_if.master rx,
    output logic       pfrmerr,
    output logic       povrun,
    output logic [5:0] pcat
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_PAR   = 2'd2;
    localparam logic [1:0] ST_END   = 2'd3;

    localparam logic [4:0] WORD_CNT = 5'(WORD_W);
    localparam int         NUM_CH   = 6;

    // Frame assembly state
    logic [1:0]        state_q, state_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic              par_q, par_d;      // running XOR of data bits
    logic              perr_q, perr_d;    // parity result of the closed frame
    logic [2:0]        ch_q, ch_d;

    // Output register, flags and credits
    logic              prvalid_q, prvalid_d;
    logic [WORD_W-1:0] prdata_q, prdata_d;
    logic [2:0]        prch_q, prch_d;
    logic              pcomperr_q, pcomperr_d;
    logic              pfrmerr_q, pfrmerr_d;
    logic              povrun_q, povrun_d;
    logic [5:0]        pcat_q, pcat_d;

    // Per-cycle events
    logic frm_err;       // framing violation detected by the FSM
    logic commit;        // pend closes a complete frame in END
    logic ch_ok;         // latched channel is one that owns a credit bit
    logic transfer;      // consumer takes the current output word
    logic load;          // committed word goes into the output register
    logic overrun;       // committed word dropped: output still occupied
    logic timeout_abort; // frame abandoned after a strobe-free stretch

`ifdef APEX_SDO_RX_TIMEOUT_EN
    logic [3:0] idle_q, idle_d;

    // Count strobe-free cycles while a frame is open
    always_comb begin
        if (state_q == ST_IDLE || pfbi || pend) begin
            idle_d = '0;
        end else begin
            idle_d = idle_q + 4'd1;
        end
        timeout_abort = (state_q != ST_IDLE) && !pfbi && !pend && (idle_q == 4'hF);
    end

    // Idle counter register
    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    assign timeout_abort = 1'b0;
`endif

    // Frame FSM: shift data, record parity, detect framing errors and commits
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        perr_d  = perr_q;
        ch_d    = ch_q;
        frm_err = 1'b0;
        commit  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pfbi && pend) begin
                    // Collision at frame start: flag it, sample nothing
                    frm_err = 1'b1;
                end else if (pfbi) begin
                    shreg_d    = '0;
                    shreg_d[0] = psdo;
                    par_d      = psdo;
                    ch_d       = pibt;
                    cnt_d      = 5'd1;
                    state_d    = (WORD_W == 1) ? ST_PAR : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (pend) begin
                    frm_err = 1'b1;
                    state_d = ST_IDLE;
                end else if (pfbi) begin
                    for (int i = 0; i < WORD_W; i++) begin
                        if (cnt_q == 5'(i)) begin
                            shreg_d[i] = psdo;
                        end
                    end
                    par_d = par_q ^ psdo;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q + 5'd1 == WORD_CNT) begin
                        state_d = ST_PAR;
                    end
                end
            end
            ST_PAR: begin
                if (pend) begin
                    frm_err = 1'b1;
                    state_d = ST_IDLE;
                end else if (pfbi) begin
                    // Even parity: an odd total of ones is an error
                    perr_d  = par_q ^ psdo;
                    state_d = ST_END;
                end
            end
            default: begin // ST_END
                if (pfbi) begin
                    frm_err = 1'b1;
                    state_d = ST_IDLE;
                end else if (pend) begin
                    commit  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
        endcase

        if (timeout_abort) begin
            frm_err = 1'b1;
            state_d = ST_IDLE;
        end

        // Idle always carries a zero bit count
        if (state_d == ST_IDLE) begin
            cnt_d = '0;
        end
    end

    // Commit decision and output-register handshake
    always_comb begin
        transfer = prvalid_q && rx.prready;
        ch_ok    = (ch_q < 3'(NUM_CH));
        load     = commit && ch_ok && (!prvalid_q || rx.prready);
        overrun  = commit && ch_ok && prvalid_q && !rx.prready;

        prvalid_d  = load ? 1'b1 : (prvalid_q && !transfer);
        prdata_d   = load ? shreg_q : prdata_q;
        prch_d     = load ? ch_q : prch_q;
        pcomperr_d = load ? perr_q : pcomperr_q;

        // A commit to an invalid channel is reported as a framing error
        pfrmerr_d = frm_err || (commit && !ch_ok);

        if (overrun) begin
            povrun_d = 1'b1;
        end else if (piclr) begin
            povrun_d = 1'b0;
        end else begin
            povrun_d = povrun_q;
        end

        // Credit returns on transfer; a same-edge load of that channel wins
        pcat_d = pcat_q;
        for (int c = 0; c < NUM_CH; c++) begin
            if (transfer && prch_q == 3'(c)) begin
                pcat_d[c] = 1'b1;
            end
            if (load && ch_q == 3'(c)) begin
                pcat_d[c] = 1'b0;
            end
        end
    end

    // Frame assembly registers
    always_ff @(posedge pclk or posedge prst) begin
        // NOTE: the shift register is reset too, so prdata can never expose
        // a stale or X word even though it only loads on a commit.
        if (prst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
            ch_q    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so
            // every register samples the pre-edge value of its sources.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            perr_q  <= perr_d;
            ch_q    <= ch_d;
        end
    end

    // Output register, status flags and credit registers
    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            prvalid_q  <= 1'b0;
            prdata_q   <= '0;
            prch_q     <= '0;
            pcomperr_q <= 1'b0;
            pfrmerr_q  <= 1'b0;
            povrun_q   <= 1'b0;
            pcat_q     <= 6'b111111;
        end else begin
            prvalid_q  <= prvalid_d;
            prdata_q   <= prdata_d;
            prch_q     <= prch_d;
            pcomperr_q <= pcomperr_d;
            pfrmerr_q  <= pfrmerr_d;
            povrun_q   <= povrun_d;
            pcat_q     <= pcat_d;
        end
    end

    assign rx.prvalid  = prvalid_q;
    assign rx.prdata   = prdata_q;
    assign rx.prch     = prch_q;
    assign rx.pcomperr = pcomperr_q;
    assign pfrmerr     = pfrmerr_q;
    assign povrun      = povrun_q;
    assign pcat        = pcat_q;

endmodule
